// File: rtl/mccoy_host.sv
// Host controller that clocks, resets and feeds instructions to a small external core.
// Optional build macro MCCOY_HOST_BREAKPOINT_EN adds a PC breakpoint (bp_en, bp_addr, bp_hit).
module mccoy_host #(
   parameter int PROG_AW = 4,
   parameter int RST_CYC = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_valid,
   input  logic [PROG_AW-1:0] load_addr,
   input  logic [5:0]         load_data,
   input  logic               start,
   input  logic [7:0]         run_cycles,
   input  logic [7:0]         core_out,
`ifdef MCCOY_HOST_BREAKPOINT_EN
   input  logic               bp_en,
   input  logic [7:0]         bp_addr,
   output logic               bp_hit,
`endif
   output logic [7:0]         core_in,
   output logic [7:0]         pc_cap,
   output logic [7:0]         x8_cap,
   output logic               busy,
   output logic               done
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] RST_HI = 3'd1;
   localparam logic [2:0] RST_LO = 3'd2;
   localparam logic [2:0] RUN_HI = 3'd3;
   localparam logic [2:0] RUN_LO = 3'd4;

   localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [RCW-1:0] RC_LAST = RCW'(RST_CYC - 1);

   logic [5:0]         mem [0:(1<<PROG_AW)-1];

   logic [2:0]         state, state_d;
   logic [7:0]         cnt, cnt_d;
   logic [RCW-1:0]     rcnt, rcnt_d;
   logic [5:0]         instr_reg, instr_d;
   logic [7:0]         pc_d, x8_d, core_in_d;
   logic               done_d;
   logic               mem_we;
   logic               start_acc;
   logic               bp_stop;

`ifdef MCCOY_HOST_BREAKPOINT_EN
   assign bp_stop = bp_en && (core_out == bp_addr);
`else
   assign bp_stop = 1'b0;
`endif

   assign busy = (state != IDLE);

   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      rcnt_d    = rcnt;
      instr_d   = instr_reg;
      pc_d      = pc_cap;
      x8_d      = x8_cap;
      done_d    = 1'b0;
      mem_we    = 1'b0;
      start_acc = 1'b0;
      case (state)
         IDLE: begin
            mem_we = load_valid;
            if (start) begin
               start_acc = 1'b1;
               cnt_d     = run_cycles;
               rcnt_d    = '0;
               state_d   = RST_HI;
            end
         end
         RST_HI: state_d = RST_LO;
         RST_LO: begin
            if (rcnt == RC_LAST) begin
               rcnt_d = '0;
               if (cnt == 8'd0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  // The first run cycle always starts from the reset vector.
                  state_d = RUN_HI;
                  instr_d = mem[0];
               end
            end else begin
               rcnt_d  = rcnt + 1'b1;
               state_d = RST_HI;
            end
         end
         RUN_HI: begin
            pc_d = core_out;
            if (bp_stop) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = RUN_LO;
            end
         end
         RUN_LO: begin
            x8_d    = core_out;
            cnt_d   = cnt - 8'd1;
            instr_d = mem[pc_cap[PROG_AW-1:0]];
            if (cnt == 8'd1) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = RUN_HI;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // core_in is registered from the next state so it always matches the current state.
   always_comb begin
      core_in_d = 8'd0;
      case (state_d)
         RST_HI:  core_in_d = 8'b0000_0011;
         RST_LO:  core_in_d = 8'b0000_0010;
         RUN_HI:  core_in_d = {instr_d, 2'b01};
         RUN_LO:  core_in_d = {instr_d, 2'b00};
         default: core_in_d = 8'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         rcnt      <= '0;
         instr_reg <= 6'd0;
         pc_cap    <= 8'd0;
         x8_cap    <= 8'd0;
         core_in   <= 8'd0;
         done      <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         rcnt      <= rcnt_d;
         instr_reg <= instr_d;
         pc_cap    <= pc_d;
         x8_cap    <= x8_d;
         core_in   <= core_in_d;
         done      <= done_d;
      end
   end

   // Program memory survives reset; it is written only while idle.
   always_ff @(posedge clk) begin
      if (mem_we && !reset)
         mem[load_addr] <= load_data;
   end

`ifdef MCCOY_HOST_BREAKPOINT_EN
   always_ff @(posedge clk) begin
      if (reset)
         bp_hit <= 1'b0;
      else if (start_acc)
         bp_hit <= 1'b0;
      else if (state == RUN_HI && bp_stop)
         bp_hit <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_mccoy_host.sv
// Scoreboard bench for mccoy_host: a driver plans each run from the program rules, a monitor checks.
// Builds with or without MCCOY_HOST_BREAKPOINT_EN.
module tb_mccoy_host;

   localparam int AW = 4;
   localparam int RC = 2;
`ifdef MCCOY_HOST_BREAKPOINT_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic          load_valid;
   logic [AW-1:0] load_addr;
   logic [5:0]    load_data;
   logic          start;
   logic [7:0]    run_cycles;
   logic [7:0]    core_out;
   logic [7:0]    core_in, pc_cap, x8_cap;
   logic          busy, done;
   logic          bp_en_t;
   logic [7:0]    bp_addr_t;
`ifdef MCCOY_HOST_BREAKPOINT_EN
   logic          bp_hit;
`endif

   mccoy_host #(.PROG_AW(AW), .RST_CYC(RC)) dut (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_addr(load_addr),
      .load_data(load_data), .start(start), .run_cycles(run_cycles), .core_out(core_out),
`ifdef MCCOY_HOST_BREAKPOINT_EN
      .bp_en(bp_en_t), .bp_addr(bp_addr_t), .bp_hit(bp_hit),
`endif
      .core_in(core_in), .pc_cap(pc_cap), .x8_cap(x8_cap), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] pc;
      logic [7:0] x8;
      logic       bp;
   } done_t;

   logic [7:0] exp_ci [$];
   done_t      exp_done [$];
   logic [5:0] mref [0:15];
   logic [7:0] m_pc, m_x8;
   logic       m_bp;
   int         n_tests = 0;
   int         n_fail = 0;

   // Model core: PC while its clock is high, x8 while low; advances once per run cycle.
   logic [7:0] pcs [0:63];
   logic [7:0] x8s [0:63];
   logic [5:0] run_idx = 6'd0;
   assign core_out = core_in[0] ? pcs[run_idx] : x8s[run_idx];
   always @(posedge clk) begin
      if (start && !busy) run_idx <= 6'd0;
      else if (busy && core_in[1:0] == 2'b00) run_idx <= run_idx + 6'd1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected core_in per host cycle of a run and the final capture values.
   task automatic plan_run(input logic [7:0] n);
      logic [5:0] instr;
      logic       stopped;
      for (int r = 0; r < RC; r++) begin
         exp_ci.push_back(8'h03);
         exp_ci.push_back(8'h02);
      end
      instr   = mref[0];
      stopped = 1'b0;
      m_bp    = 1'b0;
      for (int k = 0; k < int'(n); k++) begin
         exp_ci.push_back({instr, 2'b01});
         m_pc = pcs[k];
         if (BP && bp_en_t && pcs[k] == bp_addr_t) begin
            stopped = 1'b1;
            break;
         end
         exp_ci.push_back({instr, 2'b00});
         m_x8  = x8s[k];
         instr = mref[m_pc % 16];
      end
      m_bp = stopped;
      exp_done.push_back('{pc: m_pc, x8: m_x8, bp: m_bp});
   endtask

   always @(negedge clk) begin
      done_t d;
      if (!reset) begin
         if (busy) begin
            if (exp_ci.size() == 0) check("unexpected_busy", 32'd1, 32'd0);
            else check("core_in", core_in, exp_ci.pop_front());
         end else begin
            check("idle_core_in", core_in, 8'd0);
         end
         if (done) begin
            if (exp_done.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               d = exp_done.pop_front();
               check("pc_cap", pc_cap, d.pc);
               check("x8_cap", x8_cap, d.x8);
`ifdef MCCOY_HOST_BREAKPOINT_EN
               check("bp_hit", bp_hit, d.bp);
`endif
            end
         end else if (!busy && exp_ci.size() == 0 && exp_done.size() != 0) begin
            check("done_missing", 32'd0, 32'd1);
            void'(exp_done.pop_front());
         end
      end
   end

   task automatic load(input logic [3:0] a, input logic [5:0] d);
      @(negedge clk);
      load_valid = 1'b1; load_addr = a; load_data = d;
      mref[a] = d;
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic do_start(input logic [7:0] n, input bit ld, input logic [3:0] la, input logic [5:0] ldd);
      @(negedge clk);
      if (ld) mref[la] = ldd;
      plan_run(n);
      start = 1'b1; run_cycles = n;
      load_valid = ld; load_addr = la; load_data = ldd;
      @(negedge clk);
      start = 1'b0; load_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int t = 0;
      while ((exp_ci.size() != 0 || exp_done.size() != 0) && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) begin
         check({tag, "_timeout"}, 32'd1, 32'd0);
         exp_ci.delete();
         exp_done.delete();
      end
      @(negedge clk);
   endtask

   task automatic rand_core(input int n);
      for (int k = 0; k < n; k++) begin
         pcs[k] = 8'($urandom_range(0, 255));
         x8s[k] = 8'($urandom_range(0, 255));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lo_seen, t;
      reset = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0;
      start = 1'b0; run_cycles = '0; bp_en_t = 1'b0; bp_addr_t = 8'h00;
      m_pc = 8'h00; m_x8 = 8'h00; m_bp = 1'b0;
      for (int k = 0; k < 64; k++) begin pcs[k] = 8'h00; x8s[k] = 8'h00; end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_core_in", core_in, 8'h00);
      check("rst_pc_cap", pc_cap, 8'h00);
      check("rst_x8_cap", x8_cap, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);

      for (int a = 0; a < 16; a++) load(4'(a), 6'($urandom_range(0, 62)));
      load(4'd0, 6'h01); load(4'd1, 6'h02); load(4'd2, 6'h03); load(4'd3, 6'h04);
      load(4'd5, 6'h15);

      // Basic three-cycle run walking the first program words.
      pcs[0] = 8'h01; pcs[1] = 8'h02; pcs[2] = 8'h03;
      x8s[0] = 8'hA1; x8s[1] = 8'hA2; x8s[2] = 8'hA3;
      do_start(8'd3, 1'b0, 4'd0, 6'd0);
      check("busy_after_start", busy, 1'b1);
      wait_drain("run3");

      // Zero-length run: reset sequence only, captures unchanged.
      do_start(8'd0, 1'b0, 4'd0, 6'd0);
      wait_drain("run0");

      // PC beyond program depth wraps into memory.
      pcs[0] = 8'h13; pcs[1] = 8'h13; x8s[0] = 8'h55; x8s[1] = 8'h66;
      do_start(8'd2, 1'b0, 4'd0, 6'd0);
      wait_drain("wrap");

      // Loads and starts during a run are ignored.
      rand_core(4);
      do_start(8'd4, 1'b0, 4'd0, 6'd0);
      repeat (2) @(negedge clk);
      load_valid = 1'b1; load_addr = 4'd5; load_data = 6'h3F; start = 1'b1; run_cycles = 8'd9;
      @(negedge clk);
      load_valid = 1'b0; start = 1'b0;
      wait_drain("ignored_load");
      pcs[0] = 8'h05; pcs[1] = 8'h25; x8s[0] = 8'h01; x8s[1] = 8'h02;
      do_start(8'd2, 1'b0, 4'd0, 6'd0);
      wait_drain("mem5_readback");

      // Reset during the second RUN_LO of a ten-cycle run.
      rand_core(10);
      do_start(8'd10, 1'b0, 4'd0, 6'd0);
      lo_seen = 0; t = 0;
      while (lo_seen < 2 && t < 100) begin
         if (busy && core_in[1:0] == 2'b00) lo_seen++;
         if (lo_seen < 2) @(negedge clk);
         t++;
      end
      check("abort_reached_lo2", lo_seen, 2);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_ci.delete(); exp_done.delete();
      m_pc = 8'h00; m_x8 = 8'h00; m_bp = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_core_in", core_in, 8'h00);
      check("abort_done", done, 1'b0);
      check("abort_pc_cap", pc_cap, 8'h00);
      repeat (3) @(negedge clk);

      // Randomized programs, lengths and same-cycle loads.
      for (int i = 0; i < 10; i++) begin
         bit ld;
         rand_core(12);
         ld = ($urandom_range(0, 1) == 1);
         if (BP) begin
            bp_en_t = ($urandom_range(0, 2) == 0);
            bp_addr_t = pcs[$urandom_range(0, 11)];
         end
         do_start(8'($urandom_range(0, 10)), ld, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)));
         wait_drain("random");
      end
      bp_en_t = 1'b0;

`ifdef MCCOY_HOST_BREAKPOINT_EN
      // Breakpoint stops a long run at the matching PC, then clears on the next start.
      rand_core(50);
      for (int k = 0; k < 50; k++) if (pcs[k] == 8'h02) pcs[k] = 8'h07;
      pcs[6] = 8'h02;
      bp_en_t = 1'b1; bp_addr_t = 8'h02;
      do_start(8'd50, 1'b0, 4'd0, 6'd0);
      wait_drain("breakpoint");
      check("bp_hit_held", bp_hit, 1'b1);
      bp_en_t = 1'b0;
      rand_core(1);
      do_start(8'd1, 1'b0, 4'd0, 6'd0);
      check("bp_hit_cleared", bp_hit, 1'b0);
      wait_drain("after_bp");
`endif

      check("queues_empty", exp_ci.size() + exp_done.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mccoy_host.md
MCCOY_HOST -- requirements
Module: mccoy_host

Interface
REQ-001 Parameter PROG_AW, default 4, program memory address width (depth 2^PROG_AW, 6-bit words).
REQ-002 Parameter RST_CYC, default 2, number of core clock periods the core reset is held after start.
REQ-003 clk  input  1  host clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load_valid  input  1  write strobe for program memory; honoured only in IDLE.
REQ-006 load_addr  input  PROG_AW  program memory write address.
REQ-007 load_data  input  6  instruction word to write.
REQ-008 start  input  1  begin a run; honoured only in IDLE.
REQ-009 run_cycles  input  8  core cycles to execute; sampled on accepted start.
REQ-010 core_out  input  8  core output bus; shows PC while core clock high, x8 while core clock low.
REQ-011 core_in  output  8  core input bus: bit0 core clock, bit1 core reset, bits7:2 instruction; registered.
REQ-012 pc_cap, x8_cap  output  8 each  last captured PC and x8.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on return to IDLE after a run.

Function
REQ-015 States: IDLE, RST_HI, RST_LO, RUN_HI, RUN_LO; each state lasts exactly one host cycle.
REQ-016 IDLE: core_in = 0; load_valid writes mem[load_addr] <= load_data; start (with or without load_valid in the same cycle) latches run_cycles into cnt and goes to RST_HI; a same-cycle load still writes.
REQ-017 RST_HI drives core_in = {6'b0,1,1}; RST_LO drives {6'b0,1,0}; pairs repeat RST_CYC times, then RUN_HI.
REQ-018 If cnt = 0 after reset sequence, go directly to IDLE with done pulse; core executes zero run cycles.
REQ-019 RUN_HI drives core_in = {instr_reg,0,1}; at the end of RUN_HI, pc_cap <= core_out.
REQ-020 RUN_LO drives core_in = {instr_reg,0,0}; at the end of RUN_LO, x8_cap <= core_out, cnt decrements, and instr_reg <= mem[pc_cap[PROG_AW-1:0]].
REQ-021 The instruction presented at any core rising edge equals mem[low PROG_AW bits of the PC captured in the preceding RUN_HI]; the first run cycle presents mem[0].
REQ-022 After RUN_LO: cnt reaching 0 -> IDLE with done=1 for one cycle; otherwise -> RUN_HI.
REQ-023 PC values above 2^PROG_AW-1 wrap modulo program depth when indexing memory; pc_cap holds the full 8 bits.
REQ-024 load_valid and start outside IDLE are ignored; memory is not modified during a run.

Reset
REQ-025 On reset: state IDLE, core_in 0, instr_reg 0, pc_cap 0, x8_cap 0, cnt 0, busy 0, done 0, bp_hit 0; memory contents retained.
REQ-026 Reset asserted mid-run aborts the run in the same edge with no done pulse; core_in = 0 in the following cycle.

Configuration
REQ-027 Macro MCCOY_HOST_BREAKPOINT_EN: when defined, adds input bp_en (1), input bp_addr (8), output bp_hit (1).
REQ-028 With the macro, when bp_en = 1 and the core_out value captured into pc_cap at the end of RUN_HI equals bp_addr, the FSM enters IDLE next instead of RUN_LO, pulses done, and sets bp_hit = 1 until the next accepted start.
REQ-029 Without the macro, those ports do not exist and runs end only by cnt reaching 0 or reset.

Verification
REQ-030 Load mem[0..3] = 6'h01,6'h02,6'h03,6'h04, start with run_cycles=3 -> busy rises, 2*RST_CYC reset cycles with core_in[1]=1, then instructions 6'h01, then mem[pc] for each captured PC; done pulses once after 3 RUN_LO states.
REQ-031 Start with run_cycles=0 -> reset sequence only, done pulses, pc_cap and x8_cap unchanged.
REQ-032 Model core returning PC 8'h13 in RUN_HI -> next instruction fetched from mem[3] (PROG_AW=4); pc_cap = 8'h13.
REQ-033 Assert reset in the second RUN_LO of a 10-cycle run -> busy 0, core_in 0 next cycle, no done pulse.
REQ-034 Pulse load_valid (addr 5, data 6'h3F) during a run -> mem[5] unchanged, confirmed by a later run reading mem[5].
REQ-035 MCCOY_HOST_BREAKPOINT_EN defined, bp_en=1, bp_addr=8'h02, run_cycles=50 -> run stops when pc_cap=8'h02, done pulses, bp_hit=1; bp_hit clears on the next start.
